// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU op codes
// and a small round-robin pointer helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] OP_SLL  = 4'b0101;
  localparam logic [CTRL_W-1:0] OP_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] OP_SLT  = 4'b1000;
  localparam logic [CTRL_W-1:0] OP_SLTU = 4'b1001;
  localparam logic [CTRL_W-1:0] OP_MUL  = 4'b1010;

  // Index following idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping,
// returned both as a one-hot grant and as an index.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
        o_any = 1'b1;
        o_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
        o_grant[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters (round robin).
// Define ALU_ARB_MUL_STALL_EN to give MUL an extra execute cycle (EXEC2).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][CTRL_W-1:0]      req_ctrl,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_op1,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_op2,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic                                rsp_eq,
  output logic [CTRL_W-1:0]                   alu_ctrl,
  output logic [DATA_WIDTH-1:0]               alu_op1,
  output logic [DATA_WIDTH-1:0]               alu_op2,
  input  logic [DATA_WIDTH-1:0]               alu_out,
  input  logic                                alu_eq,
  output logic [1:0]                          o_dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // req_ready is the one-hot round-robin grant, only offered in IDLE.
  // rsp_valid is held for the owner until its rsp_ready; other rsp_ready bits are ignored.

  state_t                  r_state;
  state_t                  w_next;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_owner;
  logic [CTRL_W-1:0]       r_ctrl;
  logic [DATA_WIDTH-1:0]   r_op1;
  logic [DATA_WIDTH-1:0]   r_op2;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_rsp_eq;

  logic [NUM_REQ-1:0]      w_grant;
  logic [PTR_W-1:0]        w_win_idx;
  logic                    w_any;
  logic                    w_accept;
  logic                    w_stall;
  logic                    w_capture;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

`ifdef ALU_ARB_MUL_STALL_EN
  assign w_stall = (r_ctrl == OP_MUL);
`else
  assign w_stall = 1'b0;
`endif

  // The grant is itself the ready, so any winner in IDLE completes a handshake.
  assign w_accept  = !rst && (r_state == IDLE) && w_any;
  assign w_capture = ((r_state == EXEC) && !w_stall) || (r_state == EXEC2);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = w_stall ? EXEC2 : RESP;
      EXEC2:   w_next = RESP;
      RESP:    if (rsp_ready[r_owner]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    alu_ctrl  = '0;
    alu_op1   = '0;
    alu_op2   = '0;
    if (!rst) begin
      if (r_state == IDLE) req_ready = w_grant;
      if (r_state == RESP) rsp_valid[r_owner] = 1'b1;
      if ((r_state == EXEC) || (r_state == EXEC2)) begin
        alu_ctrl = r_ctrl;
        alu_op1  = r_op1;
        alu_op2  = r_op2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_ctrl     <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_rsp_data <= '0;
      r_rsp_eq   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ctrl  <= req_ctrl[w_win_idx];
        r_op1   <= req_op1[w_win_idx];
        r_op2   <= req_op2[w_win_idx];
        r_owner <= w_win_idx;
        r_ptr   <= PTR_W'(wrap_inc(int'(w_win_idx), NUM_REQ));
      end
      if (w_capture) begin
        r_rsp_data <= alu_out;
        r_rsp_eq   <= alu_eq;
      end
    end
  end

  assign rsp_data    = r_rsp_data;
  assign rsp_eq      = r_rsp_eq;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DW = 32;
  localparam int NR = 2;
`ifdef ALU_ARB_MUL_STALL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][3:0]     req_ctrl;
  logic [NR-1:0][DW-1:0]  req_op1;
  logic [NR-1:0][DW-1:0]  req_op2;
  logic [NR-1:0]          rsp_valid;
  logic [NR-1:0]          rsp_ready;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_eq;
  logic [3:0]             alu_ctrl;
  logic [DW-1:0]          alu_op1;
  logic [DW-1:0]          alu_op2;
  logic [DW-1:0]          alu_out;
  logic                   alu_eq;
  logic [1:0]             dbg_state;

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ctrl    (req_ctrl),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_eq      (rsp_eq),
    .alu_ctrl    (alu_ctrl),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_out     (alu_out),
    .alu_eq      (alu_eq),
    .o_dbg_state (dbg_state)
  );

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      OP_MUL:  return a * b;
      default: return '0;
    endcase
  endfunction

  // External ALU seen by the DUT
  always_comb begin
    alu_out = alu_ref(alu_ctrl, alu_op1, alu_op2);
    alu_eq  = (alu_out == '0);
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  int gq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit            m_busy  = 1'b0;
  int            m_wait  = 0;
  int            m_ptr   = 0;
  int            m_owner = 0;
  logic [3:0]    m_ctrl  = '0;
  logic [DW-1:0] m_op1   = '0;
  logic [DW-1:0] m_op2   = '0;
  logic [DW-1:0] m_data  = '0;
  logic          m_eq    = 1'b0;

  int            win;
  logic [NR-1:0] e_ready;
  logic [NR-1:0] e_rv;
  logic [3:0]    e_ctrl;
  logic [DW-1:0] e_a;
  logic [DW-1:0] e_b;

  always @(negedge clk) begin
    win = -1;
    if (!rst && !m_busy)
      for (int i = 0; i < NR; i++)
        if (win < 0 && req_valid[(m_ptr + i) % NR]) win = (m_ptr + i) % NR;
    e_ready = '0;
    if (win >= 0) e_ready[win] = 1'b1;
    e_rv = '0;
    if (!rst && m_busy && m_wait == 0) e_rv[m_owner] = 1'b1;
    e_ctrl = '0; e_a = '0; e_b = '0;
    if (!rst && m_busy && m_wait > 0) begin
      e_ctrl = m_ctrl; e_a = m_op1; e_b = m_op2;
    end

    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("alu_ctrl", alu_ctrl, e_ctrl);
    chk("alu_op1", alu_op1, e_a);
    chk("alu_op2", alu_op2, e_b);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_eq", rsp_eq, m_eq);

    if (e_rv != '0 && rsp_ready[m_owner]) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_data", rsp_data, exp_q.pop_front());
    end
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) gq.push_back(i);

    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_data = '0; m_eq = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (win >= 0) begin
        m_busy  = 1'b1;
        m_owner = win;
        m_ctrl  = req_ctrl[win];
        m_op1   = req_op1[win];
        m_op2   = req_op2[win];
        m_ptr   = (win + 1) % NR;
        m_wait  = (MUL_LAT == 3 && m_ctrl == OP_MUL) ? 2 : 1;
        exp_q.push_back(alu_ref(m_ctrl, m_op1, m_op2));
      end
    end else if (m_wait > 0) begin
      if (m_wait == 1) begin
        m_data = alu_ref(m_ctrl, m_op1, m_op2);
        m_eq   = (m_data == '0);
      end
      m_wait--;
    end else if (rsp_ready[m_owner]) begin
      m_busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input int idx, input logic [3:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] ed, input logic ez,
                        input int lat, input int hold);
    bit ok;
    int n;
    req_ctrl[idx] = c;
    req_op1[idx]  = a;
    req_op2[idx]  = b;
    if (hold > 0) rsp_ready[idx] = 1'b0;
    req_valid[idx] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1'b1; break; end
    end
    chk("grant_seen", ok, 1);
    if (!ok) begin
      req_valid[idx] = 1'b0;
      rsp_ready[idx] = 1'b1;
      return;
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin n = k; break; end
    end
    chk("latency", n, lat);
    chk("op_data", rsp_data, ed);
    chk("op_eq", rsp_eq, ez);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("bp_valid", rsp_valid[idx], 1);
        chk("bp_data", rsp_data, ed);
        chk("bp_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready[idx] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_grant_drop(input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1'b1; break; end
    end
    chk("grant_wait", ok, 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    req_valid = '0;
    rsp_ready = '1;
    req_ctrl  = '0;
    req_op1   = '0;
    req_op2   = '0;

    // Requests during reset must not be granted
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);

    // Contention: both held, grants alternate 0,1,0,1
    req_ctrl[0] = OP_ADD; req_op1[0] = 32'd1;  req_op2[0] = 32'd2;
    req_ctrl[1] = OP_SUB; req_op1[1] = 32'd10; req_op2[1] = 32'd3;
    gq.delete();
    @(posedge clk); #1;
    req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (gq.size() >= 4) break;
    end
    req_valid = '0;
    chk("cont_count", (gq.size() >= 4), 1);
    if (gq.size() >= 4) begin
      chk("cont_g0", gq[0], 0);
      chk("cont_g1", gq[1], 1);
      chk("cont_g2", gq[2], 0);
      chk("cont_g3", gq[3], 1);
    end
    repeat (4) @(posedge clk); #1;

    // Single ops with literal results
    run_op(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 2, 0);
    run_op(1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 2, 0);
    run_op(0, OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, MUL_LAT, 0);
    run_op(0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 2, 0);
    run_op(1, 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 2, 0);

    // Backpressure on req1 while req0 waits (pointer now at 1)
    run_op(0, OP_OR, 32'h0F, 32'hF0, 32'hFF, 1'b0, 2, 0);
    req_ctrl[0] = OP_ADD; req_op1[0] = 32'd1; req_op2[0] = 32'd1;
    req_valid[0] = 1'b1;
    run_op(1, OP_XOR, 32'hFF00, 32'h0FF0, 32'hF0F0, 1'b0, 2, 4);
    wait_grant_drop(0);
    repeat (4) @(posedge clk); #1;

    // Reset in IDLE with pointer at 1 returns priority to req0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_ctrl[0] = OP_ADD; req_op1[0] = 32'd2; req_op2[0] = 32'd2;
    req_ctrl[1] = OP_ADD; req_op1[1] = 32'd3; req_op2[1] = 32'd3;
    req_valid = 2'b11;
    @(negedge clk);
    chk("ptr_rst_idle", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk); #1;

    // Reset while req1 SRA is in EXEC: no response, req0 wins next
    req_ctrl[1] = OP_SRA; req_op1[1] = 32'h8000_0000; req_op2[1] = 32'd4;
    req_valid[1] = 1'b1;
    wait_grant_drop(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_exec_norsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req_ctrl[0] = OP_ADD; req_op1[0] = 32'd4; req_op2[0] = 32'd4;
    req_valid = 2'b11;
    @(negedge clk);
    chk("ptr_rst_exec", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk); #1;
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
